// File: rtl/timer_alarm_ctrl.sv
// Round-robin alarm scheduler: one shared wrap-safe comparator visits one channel
// per cycle and raises pending/overrun flags plus a prioritised interrupt.
module timer_alarm_ctrl #(
  parameter int NCHAN = 4,
  parameter int CW    = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clock_valid,
  input  logic [31:0]      timer_in,
  input  logic             wr_en,
  input  logic             cancel,
  input  logic [CW-1:0]    wr_chan,
  input  logic [31:0]      wr_deadline,
  input  logic [31:0]      wr_interval,
  input  logic             wr_periodic,
  input  logic [NCHAN-1:0] ack,
  output logic [NCHAN-1:0] armed,
  output logic [NCHAN-1:0] pending,
  output logic [NCHAN-1:0] overrun,
  output logic             irq,
  output logic [CW-1:0]    irq_chan
);

  logic [31:0]      deadline [NCHAN];
  logic [31:0]      interval [NCHAN];
  logic [NCHAN-1:0] periodic;
  logic [CW-1:0]    scan_ptr;

  logic [31:0] delta;
  logic        blocked;
  logic        fire;

  // A clear sign bit on (timer - deadline) means the deadline is now or in the past.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    delta   = timer_in - deadline[scan_ptr];
    blocked = (wr_en || cancel) && (wr_chan == scan_ptr);
    fire    = armed[scan_ptr] && !delta[31] && !blocked;
  end

  always_ff @(posedge clock) begin
    if (clock_valid) begin
      if (!reset_n) begin
        scan_ptr <= '0;
        armed    <= '0;
        pending  <= '0;
        overrun  <= '0;
        periodic <= '0;
        // NOTE: the deadline/interval arrays are cleared too, so a channel armed
        // after reset never compares against leftover values.
        for (int i = 0; i < NCHAN; i++) begin
          deadline[i] <= '0;
          interval[i] <= '0;
        end
      end else begin
        // NOTE: non-blocking assignments throughout; later statements in this
        // block deliberately override earlier ones (write beats expiry beats ack).
        scan_ptr <= scan_ptr + CW'(1);
        pending  <= pending & ~ack;
        overrun  <= overrun & ~ack;

        if (fire) begin
          pending[scan_ptr] <= 1'b1;
          if (pending[scan_ptr] && !ack[scan_ptr]) begin
            overrun[scan_ptr] <= 1'b1;
          end
          if (periodic[scan_ptr] && (interval[scan_ptr] != '0)) begin
            deadline[scan_ptr] <= deadline[scan_ptr] + interval[scan_ptr];
          end else begin
            armed[scan_ptr] <= 1'b0;
          end
        end

        if (wr_en) begin
          deadline[wr_chan] <= wr_deadline;
          interval[wr_chan] <= wr_interval;
          periodic[wr_chan] <= wr_periodic;
          armed[wr_chan]    <= 1'b1;
          pending[wr_chan]  <= 1'b0;
          overrun[wr_chan]  <= 1'b0;
        end else if (cancel) begin
          armed[wr_chan]   <= 1'b0;
          pending[wr_chan] <= 1'b0;
          overrun[wr_chan] <= 1'b0;
        end
      end
    end
  end

  // Lowest pending index wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    irq      = |pending;
    irq_chan = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (pending[i]) irq_chan = CW'(i);
    end
  end

endmodule
